// File: rtl/gpio_pkg.sv
// Shared register offsets and helpers for the GPIO dbus peripheral.
package gpio_pkg;

  // Register select values carried on wb_dbus_adr[4:2].
  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IN      = 3'd2;
  localparam logic [2:0] REG_RISE_EN = 3'd3;
  localparam logic [2:0] REG_FALL_EN = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;
  localparam logic [2:0] REG_SET     = 3'd6;
  localparam logic [2:0] REG_CLR     = 3'd7;

  // Expand the four byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pin input conditioning: multi-stage synchroniser, one delay flop for edge
// detection, and a prime counter that suppresses edges right after reset.
module gpio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  // The pipeline and prev flop both start at 0, so a pin held high through
  // reset would look like a rise until the data has fully propagated.
  localparam int unsigned PrimeMax = SYNC_STAGES + 1;
  localparam int unsigned CntW     = $clog2(PrimeMax + 1);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [CntW-1:0]  r_prime_cnt;
  logic             w_primed;

  assign w_primed = (r_prime_cnt == CntW'(PrimeMax));

  // Shift raw pins through the synchroniser, then into the prev flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_stage[0] <= i_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
      r_prev <= r_stage[SYNC_STAGES-1];
    end
  end

  // Count clocks after reset release and saturate once edges become trustworthy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prime_cnt <= '0;
    end else if (!w_primed) begin
      r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev & {WIDTH{w_primed}};
  assign o_fall = ~o_sync & r_prev & {WIDTH{w_primed}};

endmodule

// File: rtl/gpio_port.sv
// Wishbone dbus GPIO slave: per-pin direction, synchronised input readback,
// atomic set/clear of OUT, and rise/fall edge capture into a W1C STATUS with a
// single level interrupt.
module gpio_port #(
  parameter int unsigned ADDR        = 0,
  parameter int unsigned AWIDTH      = 8,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [31:0]      wb_dbus_adr,
  input  logic [31:0]      wb_dbus_dat,
  input  logic [3:0]       wb_dbus_sel,
  input  logic             wb_dbus_we,
  input  logic             wb_dbus_cyc,
  output logic [31:0]      rdt,
  output logic             ack,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  import gpio_pkg::*;

  localparam logic [AWIDTH-1:0] AddrMatch = AWIDTH'(ADDR);

  logic             r_ack;
  logic [31:0]      r_rdt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_status;

  logic [WIDTH-1:0] w_out_d;
  logic [WIDTH-1:0] w_dir_d;
  logic [WIDTH-1:0] w_rise_en_d;
  logic [WIDTH-1:0] w_fall_en_d;
  logic [WIDTH-1:0] w_status_d;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_capture;

  logic             w_hit;
  logic             w_sel;
  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_reg;
  logic [31:0]      w_mask32;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_wdat;
  logic [31:0]      w_rdata;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  // Address bits outside the decode and register fields are intentionally ignored.
  logic             w_unused;
  assign w_unused = ^{wb_dbus_adr, wb_dbus_dat, w_mask32};

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (wb_clk),
    .i_rst_n (wb_rst_n),
    .i_pins  (gpio_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // ~ack keeps a master that still holds cyc from getting back-to-back acks.
  assign w_hit    = (wb_dbus_adr[31:32-AWIDTH] == AddrMatch);
  assign w_sel    = wb_dbus_cyc & w_hit & ~r_ack;
  assign w_wr     = w_sel & wb_dbus_we;
  assign w_rd     = w_sel & ~wb_dbus_we;
  assign w_reg    = wb_dbus_adr[4:2];
  assign w_mask32 = byte_mask(wb_dbus_sel);
  assign w_mask   = w_mask32[WIDTH-1:0];
  assign w_wdat   = wb_dbus_dat[WIDTH-1:0];

  assign w_capture = (w_rise & r_rise_en) | (w_fall & r_fall_en);

  // Next-state for the register file; STATUS gives new captures priority over W1C.
  always_comb begin
    w_out_d     = r_out;
    w_dir_d     = r_dir;
    w_rise_en_d = r_rise_en;
    w_fall_en_d = r_fall_en;
    w_w1c       = '0;
    if (w_wr) begin
      case (w_reg)
        REG_OUT:     w_out_d     = (r_out & ~w_mask) | (w_wdat & w_mask);
        REG_DIR:     w_dir_d     = (r_dir & ~w_mask) | (w_wdat & w_mask);
        REG_RISE_EN: w_rise_en_d = (r_rise_en & ~w_mask) | (w_wdat & w_mask);
        REG_FALL_EN: w_fall_en_d = (r_fall_en & ~w_mask) | (w_wdat & w_mask);
        REG_STATUS:  w_w1c       = w_wdat;
        REG_SET:     w_out_d     = r_out | w_wdat;
        REG_CLR:     w_out_d     = r_out & ~w_wdat;
        default:     ;
      endcase
    end
    w_status_d = (r_status & ~w_w1c) | w_capture;
  end

  // Read mux; write-only and unused bits return 0.
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_OUT:     w_rdata[WIDTH-1:0] = r_out;
      REG_DIR:     w_rdata[WIDTH-1:0] = r_dir;
      REG_IN:      w_rdata[WIDTH-1:0] = w_sync;
      REG_RISE_EN: w_rdata[WIDTH-1:0] = r_rise_en;
      REG_FALL_EN: w_rdata[WIDTH-1:0] = r_fall_en;
      REG_STATUS:  w_rdata[WIDTH-1:0] = r_status;
      default:     w_rdata = '0;
    endcase
  end

  // Bus handshake, read data and register state all update on the acking edge.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack     <= 1'b0;
      r_rdt     <= '0;
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
    end else begin
      r_ack     <= w_sel;
      r_rdt     <= w_rd ? w_rdata : '0;
      r_out     <= w_out_d;
      r_dir     <= w_dir_d;
      r_rise_en <= w_rise_en_d;
      r_fall_en <= w_fall_en_d;
      r_status  <= w_status_d;
    end
  end

  assign ack      = r_ack;
  assign rdt      = r_rdt;
  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;
  assign irq      = |r_status;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: directed scenarios plus random traffic,
// compared against a history-based reference model of the register map.
module tb_gpio_port;

  localparam int unsigned S     = 2;
  localparam logic [7:0]  ADDRV = 8'h40;
  localparam logic [31:0] BASE  = {ADDRV, 24'h0};
  localparam logic [31:0] BAD   = {ADDRV + 8'h1, 24'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic [31:0] gpio_in = '0;
  logic [31:0] rdt;
  logic        ack;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int n_checks = 0;
  int n_fail = 0;

  gpio_port #(
    .ADDR        (32'h40),
    .AWIDTH      (8),
    .WIDTH       (32),
    .SYNC_STAGES (S)
  ) dut (
    .wb_clk      (clk),
    .wb_rst_n    (rst_n),
    .wb_dbus_adr (adr),
    .wb_dbus_dat (dat),
    .wb_dbus_sel (sel),
    .wb_dbus_we  (we),
    .wb_dbus_cyc (cyc),
    .rdt         (rdt),
    .ack         (ack),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_out, m_dir, m_ren, m_fen, m_stat, m_rdt;
  logic        m_ack, m_rd;
  logic [31:0] hist[$];  // hist[k] = pin value sampled k+1 edges ago
  int          m_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_stat = '0;
    m_rdt = '0; m_ack = 1'b0; m_rd = 1'b0; m_edges = 0;
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back('0);
  endtask

  // Apply one clock edge to the model using the inputs the DUT sees at that edge.
  task automatic model_update();
    logic [31:0] newv, oldv, cap, w1c;
    logic        hit;
    int          r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_edges < 1000) m_edges++;
    newv = hist[S-1];  // synchronised pin value visible before this edge
    oldv = hist[S];
    cap  = '0;
    if (m_edges >= S + 2) cap = (newv & ~oldv & m_ren) | (~newv & oldv & m_fen);
    hit  = cyc && (adr[31:24] == ADDRV) && !m_ack;
    r    = int'(adr[4:2]);
    w1c  = '0;
    m_rd = 1'b0;
    m_rdt = '0;
    if (hit && !we) begin
      m_rd = 1'b1;
      case (r)
        0: m_rdt = m_out;
        1: m_rdt = m_dir;
        2: m_rdt = newv;
        3: m_rdt = m_ren;
        4: m_rdt = m_fen;
        5: m_rdt = m_stat;
        default: m_rdt = '0;
      endcase
    end
    if (hit && we) begin
      case (r)
        0: m_out = lane_merge(m_out, dat, sel);
        1: m_dir = lane_merge(m_dir, dat, sel);
        3: m_ren = lane_merge(m_ren, dat, sel);
        4: m_fen = lane_merge(m_fen, dat, sel);
        5: w1c = dat;
        6: m_out = m_out | dat;
        7: m_out = m_out & ~dat;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~w1c) | cap;
    m_ack  = hit;
    hist.push_front(gpio_in);
    hist.delete(S + 2);
  endtask

  // One clock: advance the model, then compare every visible output.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("ack", 32'(ack), 32'(m_ack));
    if (!(m_ack && !m_rd)) chk("rdt", rdt, m_rdt);
    chk("gpio_out", gpio_out, m_out);
    chk("gpio_oe", gpio_oe, m_dir);
    chk("irq", 32'(irq), 32'(m_stat != 0));
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    step();
    cyc = 1'b0; we = 1'b0;
    step();
  endtask

  task automatic wr(input int r, input logic [31:0] d, input logic [3:0] s);
    bus(1'b1, BASE | (32'(r) << 2), d, s);
  endtask

  task automatic rd(input int r, output logic [31:0] v);
    cyc = 1'b1; we = 1'b0; adr = BASE | (32'(r) << 2); sel = 4'hF;
    step();
    v = rdt;
    cyc = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Reset in the middle of a write: no ack, nothing committed.
    cyc = 1'b1; we = 1'b1; adr = BASE; dat = 32'h55; sel = 4'hF;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ack_in_reset", 32'(ack), 32'h0);
    step();
    step();
    cyc = 1'b0; we = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 8; r++) begin
      rd(r, v);
      chk("reset_reg", v, 32'h0);
    end
    chk("reset_oe", gpio_oe, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    // DIR/OUT then atomic SET and CLR.
    wr(1, 32'hFF, 4'hF);
    wr(0, 32'hA5, 4'hF);
    wr(6, 32'h0A, 4'hF);
    wr(7, 32'h21, 4'hF);
    chk("setclr_out", gpio_out, (32'hA5 | 32'h0A) & ~32'h21);
    chk("setclr_oe", gpio_oe, 32'hFF);
    rd(0, v);
    chk("rd_out", v, (32'hA5 | 32'h0A) & ~32'h21);
    rd(1, v);
    chk("rd_dir", v, 32'hFF);

    // cyc held across acks: ack pulses every other cycle.
    cyc = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    step(); chk("hold_ack1", 32'(ack), 32'h1);
    step(); chk("hold_ack2", 32'(ack), 32'h0);
    step(); chk("hold_ack3", 32'(ack), 32'h1);
    cyc = 1'b0;
    step();

    // Byte lanes, then SET ignoring sel.
    wr(0, 32'h0, 4'hF);
    wr(0, 32'hDEADBEEF, 4'b0010);
    rd(0, v);
    chk("byte_lane", v, 32'h0000BE00);
    wr(6, 32'h1, 4'b0000);
    chk("set_nosel", gpio_out, 32'h0000BE01);

    // Edge capture latency, W1C, and enable-clear retention.
    gpio_in = 32'h2;
    repeat (S + 3) step();
    wr(3, 32'h1, 4'hF);
    wr(4, 32'h2, 4'hF);
    wr(5, 32'hFFFFFFFF, 4'hF);
    gpio_in = 32'h1;
    repeat (S) step();
    chk("edge_early", 32'(irq), 32'h0);
    step();
    chk("edge_irq", 32'(irq), 32'h1);
    rd(5, v);
    chk("edge_status", v, 32'h3);
    wr(3, 32'h0, 4'hF);
    rd(5, v);
    chk("en_clear_keeps", v, 32'h3);
    wr(3, 32'h1, 4'hF);
    wr(5, 32'h1, 4'hF);
    rd(5, v);
    chk("w1c_bit0", v, 32'h2);
    wr(5, 32'h2, 4'hF);
    chk("w1c_irq", 32'(irq), 32'h0);

    // Capture and W1C on the same edge: the new capture wins.
    gpio_in = 32'h0;
    repeat (S + 2) step();
    gpio_in = 32'h1;
    repeat (S) step();
    wr(5, 32'h1, 4'hF);
    rd(5, v);
    chk("collision", v, 32'h1);

    // Non-matching address: no ack, nothing changes.
    bus(1'b1, BAD, 32'h1234, 4'hF);
    bus(1'b1, BAD | 32'h18, 32'hFFFFFFFF, 4'hF);
    rd(0, v);
    chk("bad_addr_out", v, 32'h0000BE01);
    rd(5, v);
    chk("bad_addr_status", v, 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) gpio_in = gpio_in ^ ($urandom & $urandom);
      if ($urandom_range(9) < 7) begin
        logic [31:0] a;
        a = (($urandom_range(15) == 0) ? BAD : BASE) | (32'($urandom_range(7)) << 2);
        bus(1'($urandom), a, $urandom, 4'($urandom));
      end else begin
        step();
      end
    end

    // Pins high through reset must not appear as rising edges.
    rst_n = 1'b0;
    model_reset();
    gpio_in = 32'hFFFFFFFF;
    repeat (3) step();
    rst_n = 1'b1;
    wr(3, 32'hFFFFFFFF, 4'hF);
    repeat (S + 4) step();
    rd(5, v);
    chk("false_edge_status", v, 32'h0);
    chk("false_edge_irq", 32'(irq), 32'h0);
    rd(2, v);
    chk("in_readback", v, 32'hFFFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
